// File: rtl/hilo_divider_if.sv
// Handshake and result bundle between the multicycle control/ALU muxes and
// the Hi/Lo divider.
interface hilo_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic             divby0flag;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_hi, div_lo, divby0flag
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_hi, div_lo, divby0flag
  );
endinterface

// File: rtl/hilo_divider.sv
// Sequential signed restoring divider feeding the Hi/Lo registers.
// Quotient -> div_lo, remainder -> div_hi, one quotient bit per cycle.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per cycle on magnitudes, WIDTH steps
// SIGN  | apply result signs and load div_hi/div_lo
// DONE  | result valid, done pulse; a new start is accepted here too
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  hilo_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] div_hi_q, div_hi_d;
  logic [WIDTH-1:0] div_lo_q, div_lo_d;
  logic             divby0_q, divby0_d;

  logic             accept;
  logic             dvs_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign dvs_zero = (bus.divisor == '0);

  // Step the partial remainder: bring in the next dividend bit, then test-subtract.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_hi_q  <= '0;
      div_lo_q  <= '0;
      divby0_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div_hi_q  <= div_hi_d;
      div_lo_q  <= div_lo_d;
      divby0_q  <= divby0_d;
    end
  end

  // Next-state decode; a zero divisor bounces straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept && !dvs_zero) state_d = CALC;
        else                     state_d = IDLE;
      end
      CALC: begin
        if (cnt_q == CW'(1)) state_d = SIGN;
      end
      SIGN:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand capture, restoring step, sign fix-up.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div_hi_d  = div_hi_q;
    div_lo_d  = div_lo_q;
    divby0_d  = accept && dvs_zero;

    if (accept && !dvs_zero) begin
      // Magnitude of the most negative value wraps to itself, which is
      // exactly its unsigned magnitude.
      neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_rem_d = bus.dividend[WIDTH-1];
      quo_d     = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
      dvs_d     = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
      rem_d     = '0;
      cnt_d     = CW'(WIDTH);
    end else if (state_q == CALC) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
    end else if (state_q == SIGN) begin
      div_lo_d = neg_quo_q ? -quo_q : quo_q;
      div_hi_d = neg_rem_q ? -rem_q : rem_q;
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.busy = (state_q == CALC) || (state_q == SIGN);
    bus.done = (state_q == DONE);
  end

  assign bus.div_hi     = div_hi_q;
  assign bus.div_lo     = div_lo_q;
  assign bus.divby0flag = divby0_q;

endmodule

// File: doc/hilo_divider.md
Name: hilo_divider

Overview:
- Sequential signed 32-bit divider for the multicycle MIPS datapath.
- Sits between the ALU source muxes (operand A and operand B) and the Hi/Lo registers.
- Executes DIV: quotient goes to Lo, remainder goes to Hi.
- The control FSM starts it with a one-cycle pulse, stalls on busy, and loads Hi/Lo on done. A divide-by-zero is reported to the exception logic.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified. Iteration counter width is clog2(WIDTH)+1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; operands sampled on the same edge
- dividend  in  WIDTH  signed dividend (operand A)
- divisor  in  WIDTH  signed divisor (operand B)
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse; div_hi/div_lo hold the new result in this cycle
- div_hi  out  WIDTH  remainder (to Hi)
- div_lo  out  WIDTH  quotient (to Lo)
- divby0flag  out  1  one-cycle pulse when start is accepted with divisor==0

Behaviour:
- Reset (synchronous, active-high; wins over everything):
  - state=IDLE; busy=0, done=0, divby0flag=0, div_hi=0, div_lo=0; all internal registers cleared.
- States: IDLE, CALC, SIGN, DONE.
- Start acceptance:
  - Accepted only in IDLE or DONE. Ignored in CALC/SIGN; operands are not re-sampled.
  - Operands are sampled only on the accept edge. Later input changes have no effect.
- Accept with divisor==0 (edge T):
  - T+1: divby0flag=1, state=IDLE, busy=0, done=0.
  - div_hi/div_lo keep their previous values.
- Accept with divisor!=0 (edge T):
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Latch |dividend| and |divisor| as unsigned WIDTH-bit values; |0x80000000| = 0x80000000.
  - Clear the partial remainder (WIDTH+1 bits); counter=WIDTH; state=CALC.
- CALC, one restoring step per cycle:
  - Shift {rem,quo} left by 1, shifting in the next quotient MSB.
  - Trial subtract |divisor|. If the result is non-negative, keep it and set quo LSB=1; otherwise restore.
  - Decrement counter. After exactly WIDTH steps (cycles T+1..T+32), go to SIGN.
- SIGN (cycle T+33):
  - div_lo = sign_q ? -quo : quo; div_hi = sign_r ? -rem : rem (two's complement, truncated to WIDTH).
  - Next state DONE.
- DONE (cycle T+34): done=1, busy=0.
  - A start in this cycle is accepted exactly as in IDLE.
  - Otherwise the next state is IDLE.
- busy is 1 in CALC and SIGN (T+1..T+33), 0 otherwise. Latency from start to done is exactly 34 cycles.
- Result semantics (MIPS DIV):
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Invariant: dividend = div_lo*divisor + div_hi (mod 2^32).
- 0x80000000 / 0xFFFFFFFF: div_lo=0x80000000, div_hi=0. No flag raised; this is the natural wrap.
- div_hi/div_lo change only in SIGN or on reset. They hold between operations.
- done and divby0flag are never high in the same cycle.
- Reset mid-operation: abort immediately; no done pulse; outputs cleared to 0.

Test Plan:
- Basic positive: start with 7/2 at T -> busy T+1..T+33; done=1 at T+34 only; div_lo=3, div_hi=1.
- Signed: -7/2 -> div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF. 7/-2 -> div_lo=0xFFFFFFFD, div_hi=1. -7/-2 -> div_lo=3, div_hi=0xFFFFFFFF.
- Divide by zero: after a 7/2 result, start 5/0 -> divby0flag=1 at T+1 only; done never pulses; outputs stay 3/1; busy stays 0.
- Corner values:
  - 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - 0xFFFFFFFF/0x80000000 -> lo=0, hi=0xFFFFFFFF.
  - 0/5 -> lo=0, hi=0.
- Handshake:
  - start 100/7 at T; start 1/1 at T+5 with changed operands -> ignored; done at T+34 with lo=14, hi=2.
  - start 9/3 during the DONE cycle -> accepted; done 34 cycles later with lo=3, hi=0.
- Reset mid-op: start 100/7, reset at T+10 -> busy=0 and outputs 0 from T+11; no done within 40 cycles.
- Random: 10k random signed pairs with divisor!=0, checked against a reference model of the invariant and the truncation rules.
